// File: rtl/ledr_sequencer.sv
// ledr_sequencer
// Autonomous pattern sequencer for the red-LED PIO. The CPU configures it via
// an Avalon-MM slave. It then steps an LED pattern at a programmable tick
// period and pushes each new pattern to the PIO data register through an
// Avalon-MM master.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   s_address[1:0]      0 CTRL {IRQ_EN, MODE[1:0], EN}, 1 PERIOD,
//                       2 PATTERN, 3 STATUS {irq_pending, running}
//   s_chipselect, s_write_n, s_writedata[31:0]
//                       slave write port (zero wait states)
//   s_readdata[31:0]    combinational read data, decoded from s_address
//   m_address[1:0]      always 0 (PIO data register)
//   m_chipselect, m_write_n, m_writedata[31:0]
//                       registered one-cycle PIO write strobe
//   irq                 wrap interrupt (only when LEDR_SEQ_IRQ_EN is defined)
//
// Optional feature macro: LEDR_SEQ_IRQ_EN. It adds wrap detection,
// irq_pending, the CTRL IRQ_EN bit and the irq port.
module ledr_sequencer #(
  parameter int          WIDTH          = 18,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
`ifdef LEDR_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE} state_t;

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic [1:0]         mode_q, mode_d;
  logic [31:0]        period_q, period_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic               dir_q, dir_d;
  logic               pend_q, pend_d;
  logic               m_cs_q, m_cs_d;
  logic               m_wr_n_q, m_wr_n_d;
  logic [31:0]        m_wdata_q, m_wdata_d;
`ifdef LEDR_SEQ_IRQ_EN
  logic               irq_en_q, irq_en_d;
  logic               irq_pend_q, irq_pend_d;
  logic [WIDTH-1:0]   last_pat_q, last_pat_d;
  logic               step_wrap;
  logic               step_taken;
`endif

  logic               wr_en, wr_ctrl, wr_period, wr_pat, wr_status;
  logic [31:0]        per_m1;
  logic               term;
  logic               go_write;
  logic [WIDTH-1:0]   step_pat;
  logic               step_dir;

  assign wr_en     = s_chipselect & ~s_write_n;
  assign wr_ctrl   = wr_en & (s_address == 2'd0);
  assign wr_period = wr_en & (s_address == 2'd1);
  assign wr_pat    = wr_en & (s_address == 2'd2);
  assign wr_status = wr_en & (s_address == 2'd3);

  // A PERIOD of 0 behaves as 1. The >= compare makes a PERIOD lowered
  // below the running count terminate on the next cycle.
  assign per_m1 = (period_q == 32'd0) ? 32'd0 : period_q - 32'd1;
  assign term   = (cnt_q >= per_m1);

  // Next pattern for the current mode.
  always_comb begin
    step_pat = pat_q;
    step_dir = dir_q;
    case (mode_q)
      2'd0: step_pat = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
      2'd1: begin
        if (!dir_q) begin
          if (pat_q[WIDTH-1]) begin
            step_dir = 1'b1;
            step_pat = pat_q >> 1;
          end else begin
            step_pat = pat_q << 1;
          end
        end else begin
          if (pat_q[0]) begin
            step_dir = 1'b0;
            step_pat = pat_q << 1;
          end else begin
            step_pat = pat_q >> 1;
          end
        end
      end
      2'd2: step_pat = ~pat_q;
      default: step_pat = pat_q + WIDTH'(1);
    endcase
  end

`ifdef LEDR_SEQ_IRQ_EN
  always_comb begin
    case (mode_q)
      2'd0:    step_wrap = pat_q[WIDTH-1];
      2'd1:    step_wrap = (step_dir != dir_q);
      2'd2:    step_wrap = ((~pat_q) == last_pat_q);
      default: step_wrap = &pat_q;
    endcase
  end
`endif

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    mode_d    = mode_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    m_cs_d    = 1'b0;
    m_wr_n_d  = 1'b1;
    m_wdata_d = m_wdata_q;
    go_write  = 1'b0;
`ifdef LEDR_SEQ_IRQ_EN
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    last_pat_d = last_pat_q;
    step_taken = 1'b0;
`endif

    if (wr_ctrl) begin
      en_d   = s_writedata[0];
      mode_d = s_writedata[2:1];
`ifdef LEDR_SEQ_IRQ_EN
      irq_en_d = s_writedata[3];
`endif
    end
    if (wr_period) period_d = s_writedata;

    // en_d is used so that enabling and disabling act on the CTRL write edge.
    case (state_q)
      S_IDLE: begin
        cnt_d = 32'd0;
        if (en_d) state_d = S_RUN;
      end
      S_RUN: begin
        if (!en_d) begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end else if (term) begin
          pat_d    = step_pat;
          dir_d    = step_dir;
          cnt_d    = 32'd0;
          go_write = 1'b1;
`ifdef LEDR_SEQ_IRQ_EN
          step_taken = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WRITE: begin
        cnt_d   = 32'd0;
        state_d = en_d ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A CPU pattern write overrides any step in the same cycle. One that lands
    // on a WRITE cycle is deferred by one cycle so strobes never abut.
    if (wr_pat) begin
      pat_d = s_writedata[WIDTH-1:0];
      dir_d = dir_q;
`ifdef LEDR_SEQ_IRQ_EN
      last_pat_d = s_writedata[WIDTH-1:0];
      step_taken = 1'b0;
`endif
      if (state_q == S_WRITE) begin
        pend_d = 1'b1;
      end else begin
        pend_d   = 1'b0;
        go_write = 1'b1;
        cnt_d    = 32'd0;
      end
    end else if (pend_q && (state_q != S_WRITE)) begin
      pend_d   = 1'b0;
      go_write = 1'b1;
      cnt_d    = 32'd0;
    end

    if (go_write) begin
      state_d   = S_WRITE;
      m_cs_d    = 1'b1;
      m_wr_n_d  = 1'b0;
      m_wdata_d = {{(32-WIDTH){1'b0}}, pat_d};
    end

`ifdef LEDR_SEQ_IRQ_EN
    // A wrap in the same cycle as a STATUS write keeps irq_pending set.
    if (wr_status) irq_pend_d = 1'b0;
    if (step_taken && step_wrap) irq_pend_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      mode_q    <= 2'd0;
      period_q  <= DEFAULT_PERIOD;
      cnt_q     <= 32'd0;
      pat_q     <= '0;
      dir_q     <= 1'b0;
      pend_q    <= 1'b0;
      m_cs_q    <= 1'b0;
      m_wr_n_q  <= 1'b1;
      m_wdata_q <= 32'd0;
`ifdef LEDR_SEQ_IRQ_EN
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      last_pat_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      m_cs_q    <= m_cs_d;
      m_wr_n_q  <= m_wr_n_d;
      m_wdata_q <= m_wdata_d;
`ifdef LEDR_SEQ_IRQ_EN
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      last_pat_q <= last_pat_d;
`endif
    end
  end

  always_comb begin
    s_readdata = 32'd0;
    case (s_address)
      2'd0: begin
        s_readdata[2:0] = {mode_q, en_q};
`ifdef LEDR_SEQ_IRQ_EN
        s_readdata[3] = irq_en_q;
`endif
      end
      2'd1: s_readdata = period_q;
      2'd2: s_readdata[WIDTH-1:0] = pat_q;
      default: begin
        s_readdata[0] = (state_q != S_IDLE);
`ifdef LEDR_SEQ_IRQ_EN
        s_readdata[1] = irq_pend_q;
`endif
      end
    endcase
  end

  assign m_address    = 2'b00;
  assign m_chipselect = m_cs_q;
  assign m_write_n    = m_wr_n_q;
  assign m_writedata  = m_wdata_q;
`ifdef LEDR_SEQ_IRQ_EN
  assign irq = irq_pend_q & irq_en_q;
`endif

endmodule

// File: tb/tb_ledr_sequencer.sv
// Self-checking bench for ledr_sequencer: register table, hand-written timing
// sequences and randomized pattern runs against an arithmetic step model.
module tb_ledr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  s_address = 2'd0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
`ifdef LEDR_SEQ_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ledr_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect),
    .s_write_n(s_write_n), .s_writedata(s_writedata),
    .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_writedata(m_writedata)
`ifdef LEDR_SEQ_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; logic [17:0] v;} wr_t;
  wr_t wq[$];
  bit  prev_wr = 0;

  // Record every PIO write with its cycle index; check strobe shape.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_wr = 0;
    end else begin
      if (m_chipselect == m_write_n) begin
        checks++; errors++;
        $display("FAIL strobe_pair cs=%0b wr_n=%0b required cs = ~wr_n", m_chipselect, m_write_n);
      end
      if (!m_write_n) begin
        checks++;
        if (prev_wr || m_address != 2'd0 || m_writedata[31:18] != 14'd0) begin
          errors++;
          $display("FAIL pio_write back_to_back=%0b addr=%0d data=%h required single strobe addr 0 upper zero",
                   prev_wr, m_address, m_writedata);
        end
        wq.push_back('{cyc, m_writedata[17:0]});
      end
      prev_wr = !m_write_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    s_chipselect = 1'b0; s_write_n = 1'b1; s_address = 2'd0; s_writedata = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wq.delete();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, output int t);
    @(posedge clk); #1;
    s_address = a; s_chipselect = 1'b1; s_write_n = 1'b0; s_writedata = d;
    t = cyc;
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_write_n = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    s_address = a; s_chipselect = 1'b1; s_write_n = 1'b1;
    #1 chk(name, s_readdata, exp);
    s_chipselect = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 1000 && cyc < c; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Reference step: plain arithmetic on the pattern value, dir as a flag.
  function automatic logic [18:0] mstep(input logic [17:0] p, input logic [1:0] mode, input bit dir);
    int unsigned x;
    bit d;
    x = p; d = dir;
    case (mode)
      2'd0: x = (x * 2) % 262144 + x / 131072;
      2'd1: begin
        if (!d) begin
          if (x >= 131072) begin d = 1; x = x / 2; end
          else x = (x * 2) % 262144;
        end else begin
          if (x % 2 == 1) begin d = 0; x = (x * 2) % 262144; end
          else x = x / 2;
        end
      end
      2'd2: x = 262143 - x;
      default: x = (x + 1) % 262144;
    endcase
    return {d, x[17:0]};
  endfunction

  // Wait for n recorded writes, then compare times and values with the model
  // starting from p0 with dir 0.
  task automatic expect_writes(input string nm, input int t1, input int iv, input int n,
                               input logic [17:0] p0, input logic [1:0] mode);
    logic [18:0] r;
    logic [17:0] p;
    bit d;
    int lim;
    p = p0; d = 0; lim = n * iv + 50;
    for (int i = 0; i < lim && wq.size() < n; i++) @(posedge clk);
    #1;
    checks++;
    if (wq.size() < n) begin
      errors++;
      $display("FAIL %s_count actual=%0d required=%0d", nm, wq.size(), n);
    end
    for (int k = 0; k < n && k < wq.size(); k++) begin
      r = mstep(p, mode, d);
      d = r[18]; p = r[17:0];
      chk({nm, "_time"}, wq[k].c, t1 + k * iv);
      chk({nm, "_value"}, {14'd0, wq[k].v}, {14'd0, p});
    end
  endtask

  typedef struct {logic [1:0] wa; logic [31:0] wd; logic [1:0] ra; logic [31:0] exp;} vec_t;
  vec_t vt[8];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tc, x, tr, iv, per;
    logic [17:0] rp;
    logic [1:0]  md;
    logic [18:0] r;

    vt[0] = '{2'd1, 32'd1234, 2'd1, 32'd1234};
    vt[1] = '{2'd1, 32'hFFFF_FFFF, 2'd1, 32'hFFFF_FFFF};
    vt[2] = '{2'd0, 32'h6, 2'd0, 32'h6};
`ifdef LEDR_SEQ_IRQ_EN
    vt[3] = '{2'd0, 32'hFFFF_FFFE, 2'd0, 32'hE};
`else
    vt[3] = '{2'd0, 32'hFFFF_FFFE, 2'd0, 32'h6};
`endif
    vt[4] = '{2'd2, 32'hFFFF_FFFF, 2'd2, 32'h3FFFF};
    vt[5] = '{2'd2, 32'h1234_5678, 2'd3, 32'h1};
    vt[6] = '{2'd3, 32'h0, 2'd2, 32'h05678};
    vt[7] = '{2'd3, 32'h0, 2'd3, 32'h0};

    // Reset state
    do_reset();
    chk("rst_m_write_n", {31'd0, m_write_n}, 32'd1);
    chk("rst_m_chipselect", {31'd0, m_chipselect}, 32'd0);
    chk("rst_m_writedata", m_writedata, 32'd0);
    chk("rst_m_address", {30'd0, m_address}, 32'd0);
    rd_chk("rst_ctrl", 2'd0, 32'd0);
    rd_chk("rst_period", 2'd1, 32'd50000000);
    rd_chk("rst_pattern", 2'd2, 32'd0);
    rd_chk("rst_status", 2'd3, 32'd0);
    repeat (20) @(posedge clk);
    #1 chk("rst_no_writes", wq.size(), 0);

    // Register table
    for (int i = 0; i < 8; i++) begin
      wr(vt[i].wa, vt[i].wd, t);
      rd_chk($sformatf("table_%0d", i), vt[i].ra, vt[i].exp);
    end

    // Rotate, PERIOD=3: a full lap of 18 steps
    do_reset();
    wr(2'd2, 32'h1, t); wr(2'd1, 32'd3, t); wq.delete();
    wr(2'd0, 32'h1, tc);
    expect_writes("rotate", tc + 4, 4, 18, 18'h00001, 2'd0);
    wr(2'd0, 32'h0, t);

    // Bounce, PERIOD=1: down to bit 0 and back up
    do_reset();
    wr(2'd2, 32'h20000, t); wr(2'd1, 32'd1, t); wq.delete();
    wr(2'd0, 32'h3, tc);
    expect_writes("bounce", tc + 2, 2, 18, 18'h20000, 2'd1);
    wr(2'd0, 32'h0, t);

    // Count through the wrap, PERIOD=0
    do_reset();
    wr(2'd2, 32'h3FFFE, t); wr(2'd1, 32'd0, t); wq.delete();
    wr(2'd0, 32'hF, tc);
    expect_writes("count", tc + 2, 2, 2, 18'h3FFFE, 2'd3);
`ifdef LEDR_SEQ_IRQ_EN
    chk("irq_after_wrap", {31'd0, irq}, 32'd1);
    rd_chk("status_irq", 2'd3, 32'd3);
    wr(2'd3, 32'd0, t);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
`endif
    rd_chk("status_running", 2'd3, 32'd1);
    wr(2'd0, 32'h0, t);

    // PATTERN write on the terminal-count cycle
    do_reset();
    wr(2'd2, 32'h3, t); wr(2'd1, 32'd4, t); wq.delete();
    wr(2'd0, 32'h1, tc);
    x = tc + 4;
    wait_cyc(x - 1);
    wr(2'd2, 32'h2AAAA, t);
    chk("coincide_cycle", t, x);
    wait_cyc(x + 10);
    chk("coincide_count", wq.size(), 2);
    r = mstep(18'h2AAAA, 2'd0, 0);
    if (wq.size() >= 2) begin
      chk("coincide_t0", wq[0].c, x + 1);
      chk("coincide_v0", {14'd0, wq[0].v}, 32'h2AAAA);
      chk("coincide_t1", wq[1].c, x + 6);
      chk("coincide_v1", {14'd0, wq[1].v}, {14'd0, r[17:0]});
    end
    wr(2'd0, 32'h0, t);

    // Disable at count 5 of PERIOD=10, then re-enable
    do_reset();
    wr(2'd2, 32'hF0F, t); wr(2'd1, 32'd10, t); wq.delete();
    wr(2'd0, 32'h1, tc);
    wait_cyc(tc + 5);
    wr(2'd0, 32'h0, t);
    chk("disable_cycle", t, tc + 6);
    repeat (100) @(posedge clk);
    #1 chk("disable_no_writes", wq.size(), 0);
    rd_chk("disable_status", 2'd3, 32'd0);
    rd_chk("disable_pattern", 2'd2, 32'hF0F);
    wr(2'd0, 32'h1, tr);
    expect_writes("reenable", tr + 11, 11, 1, 18'hF0F, 2'd0);
    wr(2'd0, 32'h0, t);

    // Reset asserted while the strobe is active
    do_reset();
    wr(2'd2, 32'h155, t);
    chk("midwrite_strobe", {31'd0, m_write_n}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midwrite_rst_wr_n", {31'd0, m_write_n}, 32'd1);
    chk("midwrite_rst_cs", {31'd0, m_chipselect}, 32'd0);
    chk("midwrite_rst_data", m_writedata, 32'd0);
    do_reset();

    // Randomized runs, all four modes
    for (int trial = 0; trial < 8; trial++) begin
      do_reset();
      md  = 2'(trial % 4);
      rp  = 18'($urandom);
      per = $urandom_range(0, 5);
      iv  = ((per == 0) ? 1 : per) + 1;
      wr(2'd2, {14'd0, rp}, t); wr(2'd1, per, t); wq.delete();
      wr(2'd0, {29'd0, md, 1'b1}, tc);
      expect_writes($sformatf("rand%0d", trial), tc + iv, iv, 10, rp, md);
      wr(2'd0, 32'h0, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ledr_sequencer.md
# ledr_sequencer

Autonomous pattern sequencer for the 18-bit red-LED PIO. It is an Avalon-MM slave (s1) configured by the Nios II CPU and an Avalon-MM master (m1) wired to the LED PIO's s1 port. Once enabled, it steps an 18-bit pattern (rotate, bounce, blink or count) at a programmable tick period and writes each new pattern to the PIO data register. The CPU no longer has to service LED animation.

## Interface
- WIDTH, 18: pattern width; matches the PIO out_port width.
- DEFAULT_PERIOD, 50000000: reset value of PERIOD, in clk cycles (1 s at 50 MHz).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_address  in  2  slave register select.
- s_chipselect  in  1  slave select.
- s_write_n  in  1  slave write strobe, active-low.
- s_writedata  in  32  slave write data.
- s_readdata  out  32  slave read data; zero wait states, read latency 0 (combinational on s_address).
- m_address  out  2  PIO address; constant 0 (PIO data register).
- m_chipselect  out  1  PIO select.
- m_write_n  out  1  PIO write strobe, active-low.
- m_writedata  out  32  {14'b0, pattern}.
- irq  out  1  wrap interrupt; present only with LEDR_SEQ_IRQ_EN.

## Operation
Slave registers (writes take effect when s_chipselect=1 and s_write_n=0):
- 0 CTRL: bit0 EN, bits2:1 MODE. Reads as {29'b0, MODE, EN}.
- 1 PERIOD: 32-bit step period in cycles. A value of 0 is treated as 1.
- 2 PATTERN: a write loads pattern <= writedata[17:0] and issues an immediate PIO write regardless of EN. A read returns the current pattern.
- 3 STATUS: read {30'b0, irq_pending, running}. Any write clears irq_pending.

State machine:
- IDLE: EN=0. Tick counter is held at 0. → RUN when EN=1.
- RUN: counter increments each cycle. When counter >= PERIOD-1 (PERIOD 0 → 1), compute the next pattern, clear the counter, → WRITE. If EN=0, → IDLE.
- WRITE: drive m_chipselect=1, m_write_n=0 for exactly one cycle. → RUN, or → IDLE if EN=0. A write in progress always completes.

Step functions (p = pattern):
- MODE 0 ROTATE: p <= {p[16:0], p[17]}. Wrap event when p[17]=1.
- MODE 1 BOUNCE: internal dir bit, reset 0.
  - dir=0: if p[17], set dir=1 and p>>1; otherwise p<<1.
  - dir=1: if p[0], set dir=0 and p<<1; otherwise p>>1.
  - Wrap event on any dir change. p=0 stays 0.
- MODE 2 BLINK: p <= ~p. Wrap event when the new p equals the last value written via PATTERN.
- MODE 3 COUNT: p <= p+1 modulo 2^18. Wrap event on 0x3FFFF→0.

Other rules:
- A MODE change takes effect at the next step; the pattern and dir are not reset.
- "running" = (state != IDLE).

## Timing
- Reset values: pattern 0, dir 0, CTRL 0, PERIOD DEFAULT_PERIOD, counter 0, state IDLE, irq_pending 0. Outputs: m_chipselect 0, m_write_n 1, m_writedata 0, m_address 0, irq 0, s_readdata decodes reset registers.
- Step latency: with EN=1 and PERIOD=N, the first PIO write asserts N+1 cycles after the CTRL write cycle, then every N+1 cycles (N RUN cycles plus 1 WRITE cycle).
- PATTERN write at cycle T → m_write_n low at T+1 with the new pattern. The counter clears and state goes to WRITE.
- PATTERN write coinciding with a terminal count: the CPU value wins, the step is discarded, and exactly one PIO write occurs.
- PERIOD write below the current count: terminal condition is met on the next cycle (>= compare, no 2^32 wrap-around).
- Disable mid-RUN: counter clears immediately and no further writes occur; the pattern is retained.
- Reset asserted mid-WRITE: strobe deasserts immediately (asynchronous).
- m_* outputs are registered; never more than one write per two cycles.

## Configuration
- LEDR_SEQ_IRQ_EN defined:
  - irq port exists; irq = irq_pending & CTRL bit3 (IRQ_EN).
  - irq_pending sets on any wrap event and clears on a STATUS write. A set and a clear in the same cycle: set wins.
- LEDR_SEQ_IRQ_EN undefined:
  - no irq port; CTRL bit3 and STATUS bit1 read 0; wrap detection logic is absent.

## Test plan
- Reset, then read all registers → CTRL 0, PERIOD 50000000, PATTERN 0, STATUS 0. m_write_n=1 throughout.
- PATTERN=0x00001, PERIOD=3, CTRL=0x1 (rotate) → PIO writes every 4 cycles: 0x00002, 0x00004, …; after 17 steps 0x20000, then 0x00001.
- PATTERN=0x20000, MODE=1, PERIOD=1 → writes 0x10000, 0x08000, …, 0x00001, 0x00002 (dir flips at both ends).
- MODE=3, PATTERN=0x3FFFE, PERIOD=0 → writes 0x3FFFF then 0x00000 two cycles apart. With LEDR_SEQ_IRQ_EN and IRQ_EN set, irq rises after the second write; a STATUS write clears it.
- PATTERN write in the same cycle as a terminal count → exactly one PIO write carrying the CPU value; the next step follows N+1 cycles later.
- EN cleared during RUN at count 5 of PERIOD=10 → no PIO write for 100 cycles; STATUS running=0. Re-enable → first write after 11 cycles.
